// File: rtl/cpu54_pkg.sv
// Shared constants and types for the register file and its read ports.
package cpu54_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One asynchronous read port: array mux, r0 forced to zero, optional write-through.
// Write-through forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
    import cpu54_pkg::*;
(
    input  logic [DATA_W-1:0] regs [NREG],
`ifdef REGFILE_BYPASS_EN
    input  logic              byp_valid,
    input  logic [ADDR_W-1:0] byp_addr,
    input  logic [DATA_W-1:0] byp_data,
`endif
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
        if (byp_valid && (byp_addr == raddr)) begin
            rdata = byp_data;
        end
`endif
        // r0 is forced last so neither storage nor forwarding can make it nonzero.
        if (raddr == REG_ZERO) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/regfile_32x32.sv
// MIPS 32x32 register file: two async read ports, one sync write port, clear-sweep engine.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module regfile_32x32
    import cpu54_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              iWe,
    input  logic [ADDR_W-1:0] iWaddr,
    input  logic [DATA_W-1:0] iWdata,
    input  logic [ADDR_W-1:0] iRaddr1,
    input  logic [ADDR_W-1:0] iRaddr2,
    input  logic              iClr,
    output logic [DATA_W-1:0] oRdata1,
    output logic [DATA_W-1:0] oRdata2,
    output logic              oBusy
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              we_taken;

    assign we_taken = iWe && (iWaddr != REG_ZERO) && (state_q == IDLE) && !iClr;

    always_comb begin
        regs_d  = regs_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (iClr) begin
                    state_d = SWEEP;
                    cnt_d   = ADDR_W'(1);
                    busy_d  = 1'b1;
                end else if (we_taken) begin
                    regs_d[iWaddr] = iWdata;
                end
            end
            SWEEP: begin
                regs_d[cnt_q] = '0;
                if (cnt_q == REG_RA) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        regs_d[REG_ZERO] = '0;
    end

    // NOTE: the storage array sits in the reset branch because the file must read all-zero
    // the moment rst rises; a reset-less array would keep stale data until rewritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign oBusy = busy_q;

    regfile_rd_port u_rd_port1 (
        .regs      (regs_q),
`ifdef REGFILE_BYPASS_EN
        .byp_valid (we_taken),
        .byp_addr  (iWaddr),
        .byp_data  (iWdata),
`endif
        .raddr     (iRaddr1),
        .rdata     (oRdata1)
    );

    regfile_rd_port u_rd_port2 (
        .regs      (regs_q),
`ifdef REGFILE_BYPASS_EN
        .byp_valid (we_taken),
        .byp_addr  (iWaddr),
        .byp_data  (iWdata),
`endif
        .raddr     (iRaddr2),
        .rdata     (oRdata2)
    );

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed self-checking bench for regfile_32x32 (honours REGFILE_BYPASS_EN if defined).
module tb_regfile_32x32;

    logic        clk;
    logic        rst;
    logic        iWe;
    logic [4:0]  iWaddr;
    logic [31:0] iWdata;
    logic [4:0]  iRaddr1;
    logic [4:0]  iRaddr2;
    logic        iClr;
    logic [31:0] oRdata1;
    logic [31:0] oRdata2;
    logic        oBusy;

    int checks = 0;
    int errors = 0;

    regfile_32x32 dut (
        .clk     (clk),
        .rst     (rst),
        .iWe     (iWe),
        .iWaddr  (iWaddr),
        .iWdata  (iWdata),
        .iRaddr1 (iRaddr1),
        .iRaddr2 (iRaddr2),
        .iClr    (iClr),
        .oRdata1 (oRdata1),
        .oRdata2 (oRdata2),
        .oBusy   (oBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        iWe    = 1'b1;
        iWaddr = addr;
        iWdata = data;
        tick();
        iWe    = 1'b0;
    endtask

    task automatic read1(input logic [4:0] addr, output logic [31:0] data);
        iRaddr1 = addr;
        #1;
        data = oRdata1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] same_cycle_exp;
        int          busy_cycles;

        rst = 1'b1; iWe = 1'b0; iWaddr = '0; iWdata = '0;
        iRaddr1 = '0; iRaddr2 = '0; iClr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        read1(5'd5, rd);
        check("post_reset_r5", rd, 32'h0);
        check("post_reset_busy", {31'b0, oBusy}, 32'h0);

        // Write/read r5, same-cycle value depends on forwarding.
        iWe = 1'b1; iWaddr = 5'd5; iWdata = 32'hDEADBEEF; iRaddr1 = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 32'hDEADBEEF;
`else
        same_cycle_exp = 32'h0;
`endif
        check("wr_r5_same_cycle", oRdata1, same_cycle_exp);
        tick();
        iWe = 1'b0;
        #1;
        check("wr_r5_next_cycle", oRdata1, 32'hDEADBEEF);

        // r0 write discarded, with and without forwarding.
        iWe = 1'b1; iWaddr = 5'd0; iWdata = 32'hFFFFFFFF; iRaddr2 = 5'd0;
        #1;
        check("r0_same_cycle", oRdata2, 32'h0);
        tick();
        iWe = 1'b0;
        #1;
        check("r0_next_cycle", oRdata2, 32'h0);

        // Link write to r31; r30 untouched.
        write_reg(5'd30, 32'h12345678);
        write_reg(5'd31, 32'h00400008);
        iRaddr1 = 5'd31; iRaddr2 = 5'd30;
        #1;
        check("link_r31", oRdata1, 32'h00400008);
        check("link_r30_unchanged", oRdata2, 32'h12345678);

        // Async reset mid-cycle: visible before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_r31", oRdata1, 32'h0);
        check("async_rst_r30", oRdata2, 32'h0);
        read1(5'd5, rd);
        check("async_rst_r5", rd, 32'h0);
        check("async_rst_busy", {31'b0, oBusy}, 32'h0);
        rst = 1'b0;
        tick();

        // Preload r1..r31 with their indices.
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i));
        end
        iRaddr1 = 5'd7; iRaddr2 = 5'd31;
        #1;
        check("preload_r7", oRdata1, 32'd7);
        check("preload_r31", oRdata2, 32'd31);

        // Clear request together with a write to r7: the write must be dropped.
        iClr = 1'b1; iWe = 1'b1; iWaddr = 5'd7; iWdata = 32'h00000BAD;
        tick();
        iClr = 1'b0; iWe = 1'b0;
        #1;
        check("sweep_r7_write_dropped", oRdata1, 32'd7);

        busy_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            if (!oBusy) break;
            busy_cycles++;
            if (c == 10) begin
                iRaddr1 = 5'd10; iRaddr2 = 5'd11;
                #1;
                check("sweep_partial_r10", oRdata1, 32'h0);
                check("sweep_partial_r11", oRdata2, 32'd11);
            end
            if (c == 20) begin
                iWe = 1'b1; iWaddr = 5'd2; iWdata = 32'h0000FFFF;
            end
            if (c == 21) begin
                iWe = 1'b0; iClr = 1'b1;
            end
            if (c == 22) begin
                iClr = 1'b0;
            end
            tick();
        end
        iWe = 1'b0; iClr = 1'b0;
        check("sweep_busy_cycles", 32'(busy_cycles), 32'd31);

        for (int i = 0; i < 32; i += 2) begin
            iRaddr1 = 5'(i); iRaddr2 = 5'(i + 1);
            #1;
            check($sformatf("after_sweep_r%0d", i), oRdata1, 32'h0);
            check($sformatf("after_sweep_r%0d", i + 1), oRdata2, 32'h0);
        end
        tick();
        check("no_resweep_busy", {31'b0, oBusy}, 32'h0);

        // Reset in the middle of a second sweep.
        write_reg(5'd20, 32'd20);
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        check("sweep2_busy_before_rst", {31'b0, oBusy}, 32'h1);
        iRaddr1 = 5'd20;
        #1;
        check("sweep2_r20_before_rst", oRdata1, 32'd20);
        #1;
        rst = 1'b1;
        #1;
        check("midsweep_rst_busy", {31'b0, oBusy}, 32'h0);
        check("midsweep_rst_r20", oRdata1, 32'h0);
        rst = 1'b0;
        tick();
        write_reg(5'd9, 32'hCAFEF00D);
        read1(5'd9, rd);
        check("post_rst_write_r9", rd, 32'hCAFEF00D);
        check("post_rst_idle_busy", {31'b0, oBusy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
